video_axi4s_pattern_gen: RTL
============================

Name: video_axi4s_pattern_gen

Overview:
Synthesizable, register-controlled AXI4-Stream video source: the next generation of our dummy-video front end for the MNIST/CNN pipelines. Generates frames of programmable size, component count, pattern, inter-frame gap and stall rate, so the video_mnist_* chain can be exercised on silicon without a camera. Configured over a Wishbone slave on the same clock; drives the s_axi4s_* input of downstream video blocks.

Parameters:
COMPONENT_NUM, 3, pixel components per beat
DATA_WIDTH, 8, bits per component
X_WIDTH, 12, width/x-counter bits
Y_WIDTH, 12, height/y-counter bits
FRAME_WIDTH, 16, frame counter bits
INTERVAL_WIDTH, 16, inter-frame gap counter bits
WB_ADR_WIDTH, 8, Wishbone word-address bits
WB_DAT_WIDTH, 32, Wishbone data bits
WB_SEL_WIDTH, WB_DAT_WIDTH/8, byte selects
INIT_CTL_ENABLE, 1'b0, enable bit after reset
INIT_PARAM_WIDTH, 640, pixels per line
INIT_PARAM_HEIGHT, 480, lines per frame
INIT_PARAM_INTERVAL, 1000, idle cycles between frames
INIT_PARAM_MODE, 2'd0, pattern select
INIT_PARAM_COLOR, 0, solid colour (COMPONENT_NUM*DATA_WIDTH bits)
LFSR_SEED, 16'h1234, stall LFSR seed (non-zero)

Ports:
reset  in  1  asynchronous, active-high
clk  in  1  single clock for stream and Wishbone
s_wb_adr_i  in  WB_ADR_WIDTH  word address
s_wb_dat_i  in  WB_DAT_WIDTH  write data
s_wb_dat_o  out  WB_DAT_WIDTH  read data
s_wb_we_i  in  1  write enable
s_wb_sel_i  in  WB_SEL_WIDTH  byte enables
s_wb_stb_i  in  1  strobe
s_wb_ack_o  out  1  acknowledge
m_axi4s_tuser  out  1  start of frame
m_axi4s_tlast  out  1  end of line
m_axi4s_tdata  out  COMPONENT_NUM*DATA_WIDTH  pixel, component 0 in LSBs
m_axi4s_tvalid  out  1  valid
m_axi4s_tready  in  1  ready

Behaviour:
- Clock clk and reset reset (asynchronous, active-high) are the only clock and reset; everything is clocked by clk.
- Registers (word addr): 0x00 CTL_CONTROL (b0 enable, b1 oneshot, RW); 0x01 CTL_STATUS (b0 busy, RO); 0x04 PARAM_WIDTH; 0x05 PARAM_HEIGHT; 0x06 PARAM_INTERVAL; 0x07 PARAM_MODE; 0x08 PARAM_COLOR; 0x0C FRAME_COUNT (RO). Unmapped reads return 0; writes honour s_wb_sel_i per byte.
- s_wb_ack_o = s_wb_stb_i (combinational, zero wait); s_wb_dat_o combinational from the address.
- Reset: all outputs 0; registers take their INIT_* values; FSM IDLE; frame count 0; LFSR = LFSR_SEED.
- FSM:
  - IDLE → FRAME when enable=1. Shadow-latch width/height/mode/color/interval on entry.
  - FRAME: walks x then y; on the handshake of the last pixel, → GAP.
  - GAP: counts down the interval. At 0: → FRAME (re-latch shadows) if enable=1; otherwise → IDLE.
  - oneshot=1 clears enable in hardware at FRAME entry.
- Parameter writes during FRAME/GAP do not affect the current frame.
- Latency: first tvalid is asserted on the 2nd rising edge after the edge that captures the enable write.
- Clearing enable mid-frame completes the current frame, then → IDLE.
- AXI4-S: once tvalid=1, tvalid/tdata/tuser/tlast hold until tready=1. tuser=1 only on pixel (0,0). tlast=1 on x=W-1.
- Width and height of 0 are treated as 1.
- Interval 0: pixel (0,0) of the next frame is valid in the cycle after the last-pixel handshake.
- Patterns (truncated to DATA_WIDTH):
  - 0 solid: PARAM_COLOR.
  - 1 h-ramp: every component = x.
  - 2 v-ramp: every component = y.
  - 3 checker: all-ones if (x^y) bit 3 is set, else 0.
- FRAME_COUNT increments on the last-pixel handshake and wraps modulo 2^FRAME_WIDTH.
- busy = (state != IDLE).

Optional Feature:
- Macro: VIDEO_PG_STALL_EN.
- Defined:
  - Adds PARAM_BUSY_RATE register (0x09, 8 bits, reset 0) and a 16-bit Galois LFSR that advances every cycle.
  - In FRAME, a new beat is withheld (tvalid stays 0) while lfsr[7:0] < busy_rate.
  - A stall is evaluated only when tvalid=0 or a handshake completes that cycle, so it never drops an asserted tvalid.
- Undefined: no register or LFSR; address 0x09 reads 0; beats are back-to-back.

Decomposition:
- Package video_pg_pkg: register address localparams, the mode enum (SOLID/HRAMP/VRAMP/CHECK), and the FSM state enum (IDLE/FRAME/GAP).
- One sub-module, video_pg_lfsr (parameter SEED, ports clk/reset/advance/value), instantiated only under VIDEO_PG_STALL_EN.

Test Plan:
- W=4, H=2, mode 1, interval 0, tready=1, enable → 8 beats, tdata bytes 0,1,2,3 repeating; tuser on beat 0 only; tlast on beats 3 and 7; FRAME_COUNT=1 after frame 1.
- oneshot+enable, W=3, H=3, interval 5 → exactly 9 beats, then busy=0 after the 5-cycle gap; CTL_CONTROL reads 0.
- tready toggling 1010… with mode 3 → tdata/tuser/tlast stable during every tvalid&!tready cycle; no beats lost.
- Write W=8 mid-frame (W was 4) → current frame keeps 4-pixel lines; next frame has 8.
- Assert reset during beat 5 → all outputs 0 immediately; after release, INIT values read back and FRAME_COUNT=0.
- VIDEO_PG_STALL_EN, busy_rate=128 → gaps appear between beats, tvalid never drops without a handshake; busy_rate=0 → no gaps.

Source files
------------

// File: rtl/video_pg_pkg.sv
// Shared definitions for the AXI4-Stream video pattern generator: register map,
// pattern modes and the frame sequencing states.
package video_pg_pkg;

    localparam int ADR_CTL_CONTROL    = 'h00;
    localparam int ADR_CTL_STATUS     = 'h01;
    localparam int ADR_PARAM_WIDTH    = 'h04;
    localparam int ADR_PARAM_HEIGHT   = 'h05;
    localparam int ADR_PARAM_INTERVAL = 'h06;
    localparam int ADR_PARAM_MODE     = 'h07;
    localparam int ADR_PARAM_COLOR    = 'h08;
    localparam int ADR_PARAM_BUSY     = 'h09;
    localparam int ADR_FRAME_COUNT    = 'h0C;

    typedef enum logic [1:0] {SOLID, HRAMP, VRAMP, CHECK} mode_e;
    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_e;

endpackage

// File: rtl/video_pg_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) used to pace random stream stalls.
module video_pg_lfsr #(
    parameter logic [15:0] SEED = 16'h1234
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] value
);
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance)
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign value = lfsr_q;
endmodule

// File: rtl/video_axi4s_pattern_gen.sv
// Wishbone-configured AXI4-Stream test-pattern source (solid / ramps / checker).
// Define VIDEO_PG_STALL_EN to add the PARAM_BUSY_RATE register and LFSR-paced stalls.
module video_axi4s_pattern_gen
    import video_pg_pkg::*;
#(
    parameter int COMPONENT_NUM       = 3,
    parameter int DATA_WIDTH          = 8,
    parameter int X_WIDTH             = 12,
    parameter int Y_WIDTH             = 12,
    parameter int FRAME_WIDTH         = 16,
    parameter int INTERVAL_WIDTH      = 16,
    parameter int WB_ADR_WIDTH        = 8,
    parameter int WB_DAT_WIDTH        = 32,
    parameter int WB_SEL_WIDTH        = WB_DAT_WIDTH / 8,
    parameter logic INIT_CTL_ENABLE   = 1'b0,
    parameter int INIT_PARAM_WIDTH    = 640,
    parameter int INIT_PARAM_HEIGHT   = 480,
    parameter int INIT_PARAM_INTERVAL = 1000,
    parameter logic [1:0] INIT_PARAM_MODE = 2'd0,
    parameter logic [COMPONENT_NUM*DATA_WIDTH-1:0] INIT_PARAM_COLOR = '0,
    parameter logic [15:0] LFSR_SEED  = 16'h1234
) (
    input  logic                                reset,
    input  logic                                clk,
    input  logic [WB_ADR_WIDTH-1:0]             s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]             s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]             s_wb_dat_o,
    input  logic                                s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]             s_wb_sel_i,
    input  logic                                s_wb_stb_i,
    output logic                                s_wb_ack_o,
    output logic                                m_axi4s_tuser,
    output logic                                m_axi4s_tlast,
    output logic [COMPONENT_NUM*DATA_WIDTH-1:0] m_axi4s_tdata,
    output logic                                m_axi4s_tvalid,
    input  logic                                m_axi4s_tready
);
    localparam int PIX_W = COMPONENT_NUM * DATA_WIDTH;

    function automatic logic [WB_DAT_WIDTH-1:0] wb_merge(
        input logic [WB_DAT_WIDTH-1:0] cur,
        input logic [WB_DAT_WIDTH-1:0] wdat,
        input logic [WB_SEL_WIDTH-1:0] sel
    );
        logic [WB_DAT_WIDTH-1:0] r;
        r = cur;
        for (int b = 0; b < WB_SEL_WIDTH; b++)
            if (sel[b]) r[b*8 +: 8] = wdat[b*8 +: 8];
        return r;
    endfunction

    logic                      ctl_enable_q, ctl_enable_d, ctl_oneshot_q, ctl_oneshot_d;
    logic                      en_wr, os_wr;
    logic [X_WIDTH-1:0]        width_q, width_d;
    logic [Y_WIDTH-1:0]        height_q, height_d;
    logic [INTERVAL_WIDTH-1:0] interval_q, interval_d;
    mode_e                     mode_q, mode_d;
    logic [PIX_W-1:0]          color_q, color_d;
    logic [FRAME_WIDTH-1:0]    frame_cnt_q, frame_cnt_d;
    logic [WB_DAT_WIDTH-1:0]   rdata;
    logic                      wr_en, stall;

    state_e                    state_q, state_d;
    logic [X_WIDTH-1:0]        x_q, x_d, ix, sh_wlast_q, sh_wlast_d;
    logic [Y_WIDTH-1:0]        y_q, y_d, iy, sh_hlast_q, sh_hlast_d;
    logic [INTERVAL_WIDTH-1:0] gap_q, gap_d, sh_interval_q, sh_interval_d;
    mode_e                     sh_mode_q, sh_mode_d;
    logic [PIX_W-1:0]          sh_color_q, sh_color_d, pix;
    logic                      done_q, done_d, enter, restart, hs, load;
    logic                      tvalid_q, tvalid_d, tuser_q, tuser_d, tlast_q, tlast_d;
    logic                      fend_q, fend_d;
    logic [PIX_W-1:0]          tdata_q, tdata_d;

    assign wr_en = s_wb_stb_i & s_wb_we_i;

`ifdef VIDEO_PG_STALL_EN
    logic [7:0]  busy_rate_q, busy_rate_d;
    logic [15:0] lfsr_val;

    video_pg_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (1'b1),
        .value   (lfsr_val)
    );
    assign stall = (lfsr_val[7:0] < busy_rate_q);
`else
    assign stall = 1'b0;
`endif

    // Register writes; control bits are finalised by the sequencer (oneshot clear).
    always_comb begin
        en_wr      = ctl_enable_q;
        os_wr      = ctl_oneshot_q;
        width_d    = width_q;
        height_d   = height_q;
        interval_d = interval_q;
        mode_d     = mode_q;
        color_d    = color_q;
`ifdef VIDEO_PG_STALL_EN
        busy_rate_d = busy_rate_q;
`endif
        if (wr_en) begin
            case (s_wb_adr_i)
                WB_ADR_WIDTH'(ADR_CTL_CONTROL):
                    {os_wr, en_wr} = 2'(wb_merge(WB_DAT_WIDTH'({ctl_oneshot_q, ctl_enable_q}),
                                                 s_wb_dat_i, s_wb_sel_i));
                WB_ADR_WIDTH'(ADR_PARAM_WIDTH):
                    width_d = X_WIDTH'(wb_merge(WB_DAT_WIDTH'(width_q), s_wb_dat_i, s_wb_sel_i));
                WB_ADR_WIDTH'(ADR_PARAM_HEIGHT):
                    height_d = Y_WIDTH'(wb_merge(WB_DAT_WIDTH'(height_q), s_wb_dat_i, s_wb_sel_i));
                WB_ADR_WIDTH'(ADR_PARAM_INTERVAL):
                    interval_d = INTERVAL_WIDTH'(wb_merge(WB_DAT_WIDTH'(interval_q), s_wb_dat_i, s_wb_sel_i));
                WB_ADR_WIDTH'(ADR_PARAM_MODE):
                    mode_d = mode_e'(2'(wb_merge(WB_DAT_WIDTH'(mode_q), s_wb_dat_i, s_wb_sel_i)));
                WB_ADR_WIDTH'(ADR_PARAM_COLOR):
                    color_d = PIX_W'(wb_merge(WB_DAT_WIDTH'(color_q), s_wb_dat_i, s_wb_sel_i));
`ifdef VIDEO_PG_STALL_EN
                WB_ADR_WIDTH'(ADR_PARAM_BUSY):
                    busy_rate_d = 8'(wb_merge(WB_DAT_WIDTH'(busy_rate_q), s_wb_dat_i, s_wb_sel_i));
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (s_wb_adr_i)
            WB_ADR_WIDTH'(ADR_CTL_CONTROL):    rdata = WB_DAT_WIDTH'({ctl_oneshot_q, ctl_enable_q});
            WB_ADR_WIDTH'(ADR_CTL_STATUS):     rdata = WB_DAT_WIDTH'(state_q != IDLE);
            WB_ADR_WIDTH'(ADR_PARAM_WIDTH):    rdata = WB_DAT_WIDTH'(width_q);
            WB_ADR_WIDTH'(ADR_PARAM_HEIGHT):   rdata = WB_DAT_WIDTH'(height_q);
            WB_ADR_WIDTH'(ADR_PARAM_INTERVAL): rdata = WB_DAT_WIDTH'(interval_q);
            WB_ADR_WIDTH'(ADR_PARAM_MODE):     rdata = WB_DAT_WIDTH'(mode_q);
            WB_ADR_WIDTH'(ADR_PARAM_COLOR):    rdata = WB_DAT_WIDTH'(color_q);
`ifdef VIDEO_PG_STALL_EN
            WB_ADR_WIDTH'(ADR_PARAM_BUSY):     rdata = WB_DAT_WIDTH'(busy_rate_q);
`endif
            WB_ADR_WIDTH'(ADR_FRAME_COUNT):    rdata = WB_DAT_WIDTH'(frame_cnt_q);
            default: ;
        endcase
    end

    assign s_wb_dat_o = rdata;
    assign s_wb_ack_o = s_wb_stb_i;

    // Frame sequencing. A restart from FRAME/GAP issues pixel (0,0) on the same
    // edge so an interval of N leaves exactly N idle cycles between frames.
    always_comb begin
        state_d       = state_q;
        gap_d         = gap_q;
        frame_cnt_d   = frame_cnt_q;
        sh_wlast_d    = sh_wlast_q;
        sh_hlast_d    = sh_hlast_q;
        sh_mode_d     = sh_mode_q;
        sh_color_d    = sh_color_q;
        sh_interval_d = sh_interval_q;
        ctl_enable_d  = en_wr;
        ctl_oneshot_d = os_wr;
        enter         = 1'b0;
        restart       = 1'b0;
        hs            = tvalid_q & m_axi4s_tready;
        case (state_q)
            IDLE:  enter = ctl_enable_q;
            FRAME: if (hs && fend_q) begin
                frame_cnt_d = frame_cnt_q + 1'b1;
                if (sh_interval_q != '0) begin
                    state_d = GAP;
                    gap_d   = sh_interval_q - 1'b1;
                end else if (ctl_enable_q) restart = 1'b1;
                else                       state_d = IDLE;
            end
            GAP: if (gap_q == '0) begin
                if (ctl_enable_q) restart = 1'b1;
                else              state_d = IDLE;
            end else gap_d = gap_q - 1'b1;
            default: state_d = IDLE;
        endcase
        if (enter || restart) begin
            state_d       = FRAME;
            sh_wlast_d    = (width_q == '0)  ? '0 : width_q - 1'b1;
            sh_hlast_d    = (height_q == '0) ? '0 : height_q - 1'b1;
            sh_mode_d     = mode_q;
            sh_color_d    = color_q;
            sh_interval_d = interval_q;
            // oneshot self-clears with enable so the control word reads back idle
            if (ctl_oneshot_q) begin
                ctl_enable_d  = 1'b0;
                ctl_oneshot_d = 1'b0;
            end
        end
    end

    always_comb begin
        ix  = restart ? '0 : x_q;
        iy  = restart ? '0 : y_q;
        pix = '0;
        for (int c = 0; c < COMPONENT_NUM; c++) begin
            case (sh_mode_d)
                SOLID:   pix[c*DATA_WIDTH +: DATA_WIDTH] = sh_color_d[c*DATA_WIDTH +: DATA_WIDTH];
                HRAMP:   pix[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(ix);
                VRAMP:   pix[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(iy);
                default: pix[c*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{ix[3] ^ iy[3]}};
            endcase
        end
    end

    // Output slot: refilled only when empty or being consumed, so an asserted
    // beat (and a stall decision) never disturbs a pending handshake.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        done_d   = done_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        fend_d   = fend_q;
        if (enter || restart) begin
            x_d    = '0;
            y_d    = '0;
            done_d = 1'b0;
        end
        load = (restart || (state_q == FRAME && !done_q)) &&
               (!tvalid_q || m_axi4s_tready) && !stall;
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = pix;
            tuser_d  = (ix == '0) && (iy == '0);
            tlast_d  = (ix == sh_wlast_d);
            fend_d   = (ix == sh_wlast_d) && (iy == sh_hlast_d);
            if (ix == sh_wlast_d) begin
                x_d = '0;
                if (iy == sh_hlast_d) done_d = 1'b1;
                else                  y_d    = iy + 1'b1;
            end else begin
                x_d = ix + 1'b1;
            end
        end else if (hs) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_enable_q  <= INIT_CTL_ENABLE;
            ctl_oneshot_q <= 1'b0;
            width_q       <= X_WIDTH'(INIT_PARAM_WIDTH);
            height_q      <= Y_WIDTH'(INIT_PARAM_HEIGHT);
            interval_q    <= INTERVAL_WIDTH'(INIT_PARAM_INTERVAL);
            mode_q        <= mode_e'(INIT_PARAM_MODE);
            color_q       <= INIT_PARAM_COLOR;
            frame_cnt_q   <= '0;
            state_q       <= IDLE;
            gap_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            done_q        <= 1'b0;
            sh_wlast_q    <= '0;
            sh_hlast_q    <= '0;
            sh_mode_q     <= SOLID;
            sh_color_q    <= '0;
            sh_interval_q <= '0;
            tvalid_q      <= 1'b0;
            tdata_q       <= '0;
            tuser_q       <= 1'b0;
            tlast_q       <= 1'b0;
            fend_q        <= 1'b0;
        end else begin
            ctl_enable_q  <= ctl_enable_d;
            ctl_oneshot_q <= ctl_oneshot_d;
            width_q       <= width_d;
            height_q      <= height_d;
            interval_q    <= interval_d;
            mode_q        <= mode_d;
            color_q       <= color_d;
            frame_cnt_q   <= frame_cnt_d;
            state_q       <= state_d;
            gap_q         <= gap_d;
            x_q           <= x_d;
            y_q           <= y_d;
            done_q        <= done_d;
            sh_wlast_q    <= sh_wlast_d;
            sh_hlast_q    <= sh_hlast_d;
            sh_mode_q     <= sh_mode_d;
            sh_color_q    <= sh_color_d;
            sh_interval_q <= sh_interval_d;
            tvalid_q      <= tvalid_d;
            tdata_q       <= tdata_d;
            tuser_q       <= tuser_d;
            tlast_q       <= tlast_d;
            fend_q        <= fend_d;
        end
    end

`ifdef VIDEO_PG_STALL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_rate_q <= 8'd0;
        else       busy_rate_q <= busy_rate_d;
    end
`endif

    assign m_axi4s_tvalid = tvalid_q;
    assign m_axi4s_tdata  = tdata_q;
    assign m_axi4s_tuser  = tuser_q;
    assign m_axi4s_tlast  = tlast_q;
endmodule
